// File: rtl/alu_fetch_unit.sv
// Fetch/decode stage for the 4-bit ALU: sequences a byte-wide ROM and drives B/S.
// One instruction every 2 cycles when enable is held high; enable=0 pauses in FETCH or parks in IDLE.
module alu_fetch_unit #(
   parameter int PC_WIDTH   = 12,
   parameter int PROG_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  load_pc,
   input  logic [PC_WIDTH-1:0]   pc_in,
   input  logic [PROG_WIDTH-1:0] prog_byte,
   output logic [PC_WIDTH-1:0]   pc_out,
   output logic [3:0]            B,
   output logic [2:0]            S,
   output logic                  op_valid,
   output logic                  halted
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   // The halt bit is never latched, so only the S/B fields are stored.
   logic [6:0]          instr_q, instr_d;
   logic                op_valid_q, op_valid_d;
   logic                halted_q, halted_d;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      op_valid_d = 1'b0;
      halted_d   = halted_q;

      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (enable) begin
               if (prog_byte[7]) begin
                  state_d  = HALT;
                  halted_d = 1'b1;
               end else begin
                  instr_d    = prog_byte[6:0];
                  pc_d       = pc_q + PC_WIDTH'(1);
                  state_d    = EXEC;
                  op_valid_d = 1'b1;
               end
            end
         end
         EXEC: begin
            state_d = enable ? FETCH : IDLE;
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A jump overrides any transition but leaves B/S untouched.
      if (load_pc) begin
         pc_d       = pc_in;
         state_d    = IDLE;
         op_valid_d = 1'b0;
         halted_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         instr_q    <= '0;
         op_valid_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         op_valid_q <= op_valid_d;
         halted_q   <= halted_d;
      end
   end

   assign pc_out   = pc_q;
   assign S        = instr_q[6:4];
   assign B        = instr_q[3:0];
   assign op_valid = op_valid_q;
   assign halted   = halted_q;

endmodule

// File: tb/tb_alu_fetch_unit.sv
// Bench for alu_fetch_unit: directed program scenarios with a scoreboard on op_valid pulses.
module tb_alu_fetch_unit;

   typedef struct packed {
      logic [2:0]  s;
      logic [3:0]  b;
      logic [11:0] pc;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        load_pc;
   logic [11:0] pc_in;
   logic [7:0]  prog_byte;
   logic [11:0] pc_out;
   logic [3:0]  B;
   logic [2:0]  S;
   logic        op_valid;
   logic        halted;

   logic [7:0]  rom [0:4095];
   exp_t        exp_q [$];
   int          n_checks;
   int          n_fails;

   alu_fetch_unit #(.PC_WIDTH(12), .PROG_WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .load_pc   (load_pc),
      .pc_in     (pc_in),
      .prog_byte (prog_byte),
      .pc_out    (pc_out),
      .B         (B),
      .S         (S),
      .op_valid  (op_valid),
      .halted    (halted)
   );

   assign prog_byte = rom[pc_out];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fails = n_fails + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every op_valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (op_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 32'(pc_out), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pulse_S", 32'(S), 32'(e.s));
            chk("pulse_B", 32'(B), 32'(e.b));
            chk("pulse_pc", 32'(pc_out), 32'(e.pc));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fails  = 0;
      for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
      rom[12'h000] = 8'h23;
      rom[12'h001] = 8'h1B;
      rom[12'h002] = 8'h80;
      rom[12'hFFF] = 8'h75;
      rom[12'h040] = 8'h5A;

      reset   = 1'b1;
      enable  = 1'b0;
      load_pc = 1'b0;
      pc_in   = '0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_pc", 32'(pc_out), 32'h0);
      chk("rst_B", 32'(B), 32'h0);
      chk("rst_S", 32'(S), 32'h0);
      chk("rst_op_valid", 32'(op_valid), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);

      // Run two instructions, then hit the halt byte.
      exp_q.push_back('{s: 3'b010, b: 4'b0011, pc: 12'h001});
      exp_q.push_back('{s: 3'b001, b: 4'b1011, pc: 12'h002});
      enable = 1'b1;
      tick();
      chk("run_fetch1_op_valid", 32'(op_valid), 32'h0);
      tick();
      chk("run_exec1_op_valid", 32'(op_valid), 32'h1);
      tick();
      chk("run_fetch2_op_valid", 32'(op_valid), 32'h0);
      tick();
      chk("run_exec2_op_valid", 32'(op_valid), 32'h1);
      tick();
      chk("run_fetch3_halted", 32'(halted), 32'h0);
      tick();
      chk("halt_halted", 32'(halted), 32'h1);
      chk("halt_pc", 32'(pc_out), 32'h002);
      chk("halt_op_valid", 32'(op_valid), 32'h0);
      repeat (4) tick();
      chk("halt_hold_halted", 32'(halted), 32'h1);
      chk("halt_hold_pc", 32'(pc_out), 32'h002);
      chk("halt_hold_B", 32'(B), 32'hB);
      chk("halt_hold_S", 32'(S), 32'h1);

      // Jump to the last address and wrap.
      load_pc = 1'b1;
      pc_in   = 12'hFFF;
      tick();
      load_pc = 1'b0;
      chk("load_pc_value", 32'(pc_out), 32'hFFF);
      chk("load_halted_clr", 32'(halted), 32'h0);
      chk("load_B_hold", 32'(B), 32'hB);
      chk("load_S_hold", 32'(S), 32'h1);
      exp_q.push_back('{s: 3'b111, b: 4'b0101, pc: 12'h000});
      tick();
      tick();
      chk("wrap_op_valid", 32'(op_valid), 32'h1);
      chk("wrap_pc", 32'(pc_out), 32'h000);
      tick();

      // Pause in FETCH.
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("pause_pc", 32'(pc_out), 32'h000);
         chk("pause_op_valid", 32'(op_valid), 32'h0);
      end
      exp_q.push_back('{s: 3'b010, b: 4'b0011, pc: 12'h001});
      enable = 1'b1;
      tick();
      chk("resume_op_valid", 32'(op_valid), 32'h1);

      // Jump while in EXEC: current pulse stands, nothing follows.
      load_pc = 1'b1;
      pc_in   = 12'h040;
      tick();
      load_pc = 1'b0;
      chk("exec_load_op_valid", 32'(op_valid), 32'h0);
      chk("exec_load_pc", 32'(pc_out), 32'h040);
      chk("exec_load_B_hold", 32'(B), 32'h3);
      chk("exec_load_S_hold", 32'(S), 32'h2);
      exp_q.push_back('{s: 3'b101, b: 4'b1010, pc: 12'h041});
      tick();
      chk("after_load_fetch_op_valid", 32'(op_valid), 32'h0);
      tick();
      chk("after_load_exec_op_valid", 32'(op_valid), 32'h1);

      // Reset in EXEC, together with load_pc to show reset priority.
      reset   = 1'b1;
      load_pc = 1'b1;
      pc_in   = 12'h123;
      tick();
      reset   = 1'b0;
      load_pc = 1'b0;
      enable  = 1'b0;
      chk("mid_rst_pc", 32'(pc_out), 32'h0);
      chk("mid_rst_B", 32'(B), 32'h0);
      chk("mid_rst_S", 32'(S), 32'h0);
      chk("mid_rst_op_valid", 32'(op_valid), 32'h0);
      chk("mid_rst_halted", 32'(halted), 32'h0);
      repeat (3) tick();
      chk("idle_pc", 32'(pc_out), 32'h0);
      chk("idle_op_valid", 32'(op_valid), 32'h0);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
